// File: rtl/sha_auth_pkg.sv
// Shared types and constants for the SHA-256 authentication loader.
package sha_auth_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    WRITE_WORD,
    WRITE_CTRL,
    WAIT,
    PASS,
    FAIL,
    LOCK
  } state_t;

  localparam int          SHA_WORDS      = 8;
  localparam logic [31:0] SHA_CTRL_START = 32'h1;
  localparam logic        WC_BLOCK       = 1'b0;
  localparam logic        WC_CTRL        = 1'b1;

endpackage

// File: rtl/sha_auth_loader.sv
// Packs a byte-streamed key into eight SHA block words, starts the core,
// and tracks pass/fail with a timeout and a lockout after repeated failures.
module sha_auth_loader
  import sha_auth_pkg::*;
#(
  parameter int TIMEOUT      = 256,
  parameter int MAX_ATTEMPTS = 3,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             sha_cs,
  output logic             sha_we,
  output logic             sha_wc,
  output logic [2:0]       sha_address,
  output logic [31:0]      sha_write_data,
  input  logic             sha_digest_valid,
  output logic             auth_busy,
  output logic             auth_pass,
  output logic             auth_fail,
  output logic             locked_out,
  output logic [CNT_W-1:0] fail_count
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [2:0]         word_idx;
  logic [1:0]         byte_cnt;
  logic [31:0]        shift_reg;
  logic [TIMER_W-1:0] timer;

  // Gated by reset so the handshake is withdrawn the instant reset asserts.
  assign byte_ready = (state == COLLECT) && !reset;

  // sha_* outputs are loaded on entry to the write states so they line up
  // exactly with WRITE_WORD / WRITE_CTRL, and default back to zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= COLLECT;
      word_idx       <= '0;
      byte_cnt       <= '0;
      shift_reg      <= '0;
      timer          <= '0;
      fail_count     <= '0;
      sha_cs         <= 1'b0;
      sha_we         <= 1'b0;
      sha_wc         <= 1'b0;
      sha_address    <= '0;
      sha_write_data <= '0;
      auth_busy      <= 1'b0;
      auth_pass      <= 1'b0;
      auth_fail      <= 1'b0;
      locked_out     <= 1'b0;
    end else begin
      sha_cs         <= 1'b0;
      sha_we         <= 1'b0;
      sha_wc         <= 1'b0;
      sha_address    <= '0;
      sha_write_data <= '0;
      unique case (state)
        COLLECT: begin
          if (byte_valid) begin
            shift_reg <= {shift_reg[23:0], byte_in};
            byte_cnt  <= byte_cnt + 2'd1;
            auth_busy <= 1'b1;
            auth_fail <= 1'b0;
            if (byte_cnt == 2'd3) begin
              state          <= WRITE_WORD;
              sha_cs         <= 1'b1;
              sha_we         <= 1'b1;
              sha_wc         <= WC_BLOCK;
              sha_address    <= word_idx;
              sha_write_data <= {shift_reg[23:0], byte_in};
            end
          end
        end
        WRITE_WORD: begin
          if (word_idx == 3'(SHA_WORDS - 1)) begin
            state          <= WRITE_CTRL;
            sha_cs         <= 1'b1;
            sha_we         <= 1'b1;
            sha_wc         <= WC_CTRL;
            sha_address    <= '0;
            sha_write_data <= SHA_CTRL_START;
          end else begin
            word_idx <= word_idx + 3'd1;
            state    <= COLLECT;
          end
        end
        WRITE_CTRL: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A digest on the final timeout cycle still counts as a pass.
          if (sha_digest_valid) begin
            state     <= PASS;
            auth_pass <= 1'b1;
            auth_busy <= 1'b0;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            state     <= FAIL;
            auth_fail <= 1'b1;
            auth_busy <= 1'b0;
            if (fail_count < CNT_W'(MAX_ATTEMPTS))
              fail_count <= fail_count + CNT_W'(1);
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        FAIL: begin
          if (fail_count == CNT_W'(MAX_ATTEMPTS)) begin
            state      <= LOCK;
            locked_out <= 1'b1;
          end else begin
            word_idx <= '0;
            state    <= COLLECT;
          end
        end
        PASS, LOCK: begin
          state <= state;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_auth_loader.sv
// Self-checking bench: drives keys byte by byte and compares the SHA write
// stream and auth status against an arithmetic model of the loader.
module tb_sha_auth_loader;

  localparam int TIMEOUT      = 256;
  localparam int MAX_ATTEMPTS = 3;
  localparam int CNT_W        = 2;
  localparam int PERIOD       = 10;

  logic             clk;
  logic             reset;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             sha_cs;
  logic             sha_we;
  logic             sha_wc;
  logic [2:0]       sha_address;
  logic [31:0]      sha_write_data;
  logic             sha_digest_valid;
  logic             auth_busy;
  logic             auth_pass;
  logic             auth_fail;
  logic             locked_out;
  logic [CNT_W-1:0] fail_count;

  sha_auth_loader #(
    .TIMEOUT(TIMEOUT),
    .MAX_ATTEMPTS(MAX_ATTEMPTS),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .sha_cs(sha_cs),
    .sha_we(sha_we),
    .sha_wc(sha_wc),
    .sha_address(sha_address),
    .sha_write_data(sha_write_data),
    .sha_digest_valid(sha_digest_valid),
    .auth_busy(auth_busy),
    .auth_pass(auth_pass),
    .auth_fail(auth_fail),
    .locked_out(locked_out),
    .fail_count(fail_count)
  );

  typedef struct {
    logic        we;
    logic        wc;
    logic [2:0]  addr;
    logic [31:0] data;
    time         t;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] key_bytes[32];
  int         vectors = 0;
  int         miscompares = 0;
  int         model_fails = 0;
  time        t_first;

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  // Every cycle with chip select asserted is one SHA write transaction.
  always @(negedge clk) begin
    if (sha_cs) wlog.push_back('{sha_we, sha_wc, sha_address, sha_write_data, $time});
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_fixed_key();
    logic [7:0] pat[8];
    pat = '{8'h4c, 8'h4e, 8'h49, 8'h53, 8'h6c, 8'h6e, 8'h69, 8'h73};
    for (int i = 0; i < 32; i++) key_bytes[i] = pat[i % 8];
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit rdy;
    int guard;
    ok = 1'b0;
    guard = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!ok && guard < 50) begin
      rdy = byte_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        t_first = (t_first == 0) ? $time : t_first;
      end
      step(1);
      guard++;
    end
  endtask

  // Sends the first n key bytes; optional random idle gaps; optional digest
  // pulse (held 3 cycles, no byte offered) just before byte pulse_at.
  task automatic apply_stimulus(input int n, input bit gaps, input int pulse_at);
    bit ok;
    t_first = 0;
    for (int i = 0; i < n; i++) begin
      if (i == pulse_at) begin
        byte_valid = 1'b0;
        sha_digest_valid = 1'b1;
        step(3);
        sha_digest_valid = 1'b0;
      end
      if (gaps) begin
        int g = $urandom_range(0, 3);
        if (g > 0) begin
          byte_valid = 1'b0;
          byte_in = 8'($urandom);
          step(g);
        end
      end
      send_byte(key_bytes[i], ok);
      if (!ok) check_output("byte_accept_timeout", 32'(i), 32'hffff_ffff);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_ctrl(output time t_ctrl);
    int guard = 0;
    t_ctrl = 0;
    while (!(sha_cs && sha_wc) && guard < 200) begin
      step(1);
      guard++;
    end
    if (sha_cs && sha_wc) t_ctrl = $time - 1;
    else check_output("ctrl_write_timeout", 32'(guard), 32'd0);
  endtask

  // Model: word w is key bytes 4w..4w+3 packed big-endian, then one control write.
  task automatic check_writes(input string tag);
    check_output({tag, "_write_count"}, 32'(wlog.size()), 32'd9);
    for (int w = 0; w < 9 && w < wlog.size(); w++) begin
      logic [4:0]  exp_meta;
      logic [31:0] exp_data;
      if (w < 8) begin
        exp_meta = {1'b1, 1'b0, 3'(w)};
        exp_data = key_bytes[4*w] * 32'h0100_0000 + key_bytes[4*w+1] * 32'h0001_0000
                 + key_bytes[4*w+2] * 32'h0000_0100 + 32'(key_bytes[4*w+3]);
      end else begin
        exp_meta = {1'b1, 1'b1, 3'd0};
        exp_data = 32'h1;
      end
      check_output($sformatf("%s_w%0d_meta", tag, w),
                   32'({wlog[w].we, wlog[w].wc, wlog[w].addr}), 32'(exp_meta));
      check_output($sformatf("%s_w%0d_data", tag, w), wlog[w].data, exp_data);
    end
  endtask

  // Starts at the control-write cycle; walks to the last WAIT cycle.
  task automatic run_timeout(input string tag, input bit digest_at_end);
    int exp_cnt;
    bit exp_lock;
    step(TIMEOUT);
    check_output({tag, "_no_early_fail"}, 32'(auth_fail), 32'd0);
    check_output({tag, "_busy_in_wait"}, 32'(auth_busy), 32'd1);
    sha_digest_valid = digest_at_end;
    step(1);
    sha_digest_valid = 1'b0;
    if (!digest_at_end) model_fails++;
    exp_cnt  = (model_fails < MAX_ATTEMPTS) ? model_fails : MAX_ATTEMPTS;
    exp_lock = (model_fails >= MAX_ATTEMPTS);
    check_output({tag, "_pass"}, 32'(auth_pass), 32'(digest_at_end));
    check_output({tag, "_fail"}, 32'(auth_fail), 32'(!digest_at_end));
    check_output({tag, "_fail_count"}, 32'(fail_count), 32'(exp_cnt));
    check_output({tag, "_busy_done"}, 32'(auth_busy), 32'd0);
    step(1);
    check_output({tag, "_locked"}, 32'(locked_out), 32'(exp_lock));
    check_output({tag, "_ready_after"}, 32'(byte_ready),
                 32'(!digest_at_end && !exp_lock));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    #1;
    model_fails = 0;
  endtask

  initial begin
    time t_ctrl;
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    sha_digest_valid = 1'b0;
    step(3);
    check_output("rst_cs", 32'(sha_cs), 32'd0);
    check_output("rst_we_wc_addr", 32'({sha_we, sha_wc, sha_address}), 32'd0);
    check_output("rst_data", sha_write_data, 32'd0);
    check_output("rst_status", 32'({auth_busy, auth_pass, auth_fail, locked_out}), 32'd0);
    check_output("rst_fail_count", 32'(fail_count), 32'd0);
    reset = 1'b0;
    #1;
    check_output("rst_ready", 32'(byte_ready), 32'd1);

    // Back-to-back key, digest 10 cycles after the control write.
    $display("[TB] back-to-back key with digest");
    set_fixed_key();
    wlog.delete();
    apply_stimulus(32, 1'b0, -1);
    wait_ctrl(t_ctrl);
    check_output("a_ctrl_cycle", 32'((t_ctrl + PERIOD / 2 - t_first) / PERIOD + 1), 32'd41);
    step(10);
    check_output("a_busy_wait", 32'(auth_busy), 32'd1);
    check_output("a_no_early_pass", 32'(auth_pass), 32'd0);
    sha_digest_valid = 1'b1;
    step(1);
    sha_digest_valid = 1'b0;
    check_output("a_pass", 32'(auth_pass), 32'd1);
    check_output("a_busy_done", 32'(auth_busy), 32'd0);
    check_writes("a");
    wlog.delete();
    byte_valid = 1'b1;
    byte_in = 8'h5a;
    step(10);
    byte_valid = 1'b0;
    check_output("a_pass_ignores_bytes", 32'(wlog.size()), 32'd0);
    check_output("a_pass_ready", 32'(byte_ready), 32'd0);
    check_output("a_pass_sticky", 32'(auth_pass), 32'd1);

    // Timeout attempt with a stray digest pulse during COLLECT.
    $display("[TB] timeout attempt with stray digest");
    do_reset();
    wlog.delete();
    apply_stimulus(32, 1'b0, 5);
    wait_ctrl(t_ctrl);
    run_timeout("b", 1'b0);
    check_writes("b");

    // Random key, random gaps, second failure.
    $display("[TB] random key with gaps");
    for (int i = 0; i < 32; i++) key_bytes[i] = 8'($urandom);
    wlog.delete();
    apply_stimulus(32, 1'b1, -1);
    check_output("c_fail_cleared", 32'(auth_fail), 32'd0);
    check_output("c_busy", 32'(auth_busy), 32'd1);
    wait_ctrl(t_ctrl);
    run_timeout("c", 1'b0);
    check_writes("c");

    // Third failure locks the loader.
    $display("[TB] third failure and lockout");
    set_fixed_key();
    wlog.delete();
    apply_stimulus(32, 1'b0, -1);
    wait_ctrl(t_ctrl);
    run_timeout("d", 1'b0);
    wlog.delete();
    byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      byte_in = 8'($urandom);
      step(1);
    end
    byte_valid = 1'b0;
    check_output("d_lock_no_writes", 32'(wlog.size()), 32'd0);
    check_output("d_lock_ready", 32'(byte_ready), 32'd0);
    check_output("d_lock_count", 32'(fail_count), 32'(MAX_ATTEMPTS));

    // Reset mid-word 3, then replay; digest lands on the timeout cycle.
    $display("[TB] reset mid-word then replay");
    do_reset();
    wlog.delete();
    apply_stimulus(13, 1'b0, -1);
    check_output("e_partial_writes", 32'(wlog.size()), 32'd3);
    check_output("e_busy_before", 32'(auth_busy), 32'd1);
    reset = 1'b1;
    #2;
    check_output("e_rst_status",
                 32'({auth_busy, auth_pass, auth_fail, locked_out, byte_ready}), 32'd0);
    check_output("e_rst_sha", 32'({sha_cs, sha_we, sha_wc, sha_address}), 32'd0);
    step(2);
    reset = 1'b0;
    #1;
    model_fails = 0;
    wlog.delete();
    apply_stimulus(32, 1'b1, -1);
    wait_ctrl(t_ctrl);
    run_timeout("e", 1'b1);
    check_writes("e");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_auth_loader.md
Name: sha_auth_loader

Overview:
- Upstream feeder for the PMU's lightweight SHA-256 user-authentication core.
- Accepts the user key as a byte stream with a valid/ready handshake and packs it into eight 32-bit words.
- Writes the words into the SHA core's block memory, then issues the control write.
- Waits, with a timeout, for the core's digest_valid. Produces sticky pass/fail status and enforces a lockout after repeated failures.

Parameters:
- TIMEOUT, 256: cycles to wait for digest_valid after the control write before declaring failure.
- MAX_ATTEMPTS, 3: number of failed attempts that causes permanent lockout until reset.
- CNT_W, 2: width of fail_count; must hold MAX_ATTEMPTS.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_in  in  8  key byte, MSB-first within each word.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- sha_cs  out  1  SHA core chip select.
- sha_we  out  1  SHA core write enable.
- sha_wc  out  1  0 = block-word write, 1 = control write.
- sha_address  out  3  SHA word address.
- sha_write_data  out  32  SHA write data.
- sha_digest_valid  in  1  SHA core reports a digest match.
- auth_busy  out  1  high from the first accepted byte until PASS, FAIL or LOCK.
- auth_pass  out  1  sticky authentication success.
- auth_fail  out  1  sticky last attempt failed.
- locked_out  out  1  attempts exhausted.
- fail_count  out  CNT_W  number of failed attempts.

Behaviour:
- Reset:
  - State is COLLECT; word_idx=0; byte_cnt=0; timer=0; fail_count=0.
  - All sha_* outputs are 0.
  - auth_busy, auth_pass, auth_fail and locked_out are 0; byte_ready is 1 on the first cycle after reset deasserts.
- Handshake: a byte is accepted when byte_valid && byte_ready. byte_ready=1 only in COLLECT.
- COLLECT:
  - Each accepted byte does shift_reg <= {shift_reg[23:0], byte_in} and byte_cnt++.
  - Accepting the 4th byte moves the FSM to WRITE_WORD, with byte_cnt wrapping to 0.
  - The first accepted byte after a FAIL clears auth_fail.
- WRITE_WORD (exactly 1 cycle):
  - Drives sha_cs=1, sha_we=1, sha_wc=0, sha_address=word_idx, sha_write_data=shift_reg.
  - If word_idx==7, go to WRITE_CTRL; otherwise word_idx++ and return to COLLECT.
- WRITE_CTRL (exactly 1 cycle):
  - Drives sha_cs=1, sha_we=1, sha_wc=1, sha_address=0, sha_write_data=32'h1.
  - Clears timer and goes to WAIT.
- sha_* outputs are registered and are 0 in every state other than WRITE_WORD and WRITE_CTRL.
- WAIT:
  - sha_digest_valid is sampled every cycle; if it is 1, go to PASS.
  - Otherwise timer++; when timer==TIMEOUT-1 and sha_digest_valid=0, go to FAIL.
  - If digest_valid rises on the timeout cycle itself, PASS wins.
- PASS:
  - auth_pass=1, auth_busy=0.
  - Terminal until reset; bytes are ignored.
- FAIL (1 cycle):
  - auth_fail=1 and fail_count++.
  - If the new count equals MAX_ATTEMPTS, go to LOCK; otherwise clear word_idx and go to COLLECT.
- LOCK:
  - locked_out=1, byte_ready=0.
  - Terminal until reset.
- sha_digest_valid outside WAIT is ignored.
- Minimum latency from first byte to control write, with byte_valid held high:
  - Per word: 4 collect cycles + 1 write cycle.
  - Total: 8 words × 5 cycles + 1 = 41 cycles.
- fail_count saturates at MAX_ATTEMPTS and never wraps.
- Reset asserted in any state, including mid-word or mid-WAIT, immediately zeroes all outputs. Partially loaded words are discarded; the SHA core sees no further writes.

Decomposition:
- Shared package sha_auth_pkg holds:
  - the state enum (COLLECT, WRITE_WORD, WRITE_CTRL, WAIT, PASS, FAIL, LOCK);
  - SHA_WORDS=8;
  - SHA_CTRL_START=32'h1;
  - WC_BLOCK=0 and WC_CTRL=1.
- No sub-module is needed. The byte packer is a few registers inside the FSM module.

Test Plan:
- Stream the 32 bytes 0x4c,0x4e,0x49,0x53,0x6c,0x6e,0x69,0x73 ×4 with byte_valid held high -> required SHA writes:
  - wc=0 addr0 32'h4c4e4953, addr1 32'h6c6e6973, … addr7 32'h6c6e6973;
  - then a wc=1 addr0 data 32'h1 at cycle 41;
  - the model asserts digest_valid 10 cycles later -> auth_pass=1 and auth_busy=0 the next cycle.
- Same key with the model never asserting digest_valid -> FAIL exactly TIMEOUT cycles after WAIT entry; auth_fail=1, fail_count=1, byte_ready=1 again.
- Three consecutive failed attempts -> fail_count=3, locked_out=1, byte_ready=0; further bytes cause no SHA writes.
- Randomized gaps in byte_valid -> write order and data are identical to the back-to-back case; sha_cs pulses are exactly 1 cycle each; 9 pulses in total.
- Assert reset after 13 bytes (mid word 3), then replay the full key -> the first post-reset write is addr0 32'h4c4e4953 and no stale data appears.
- Drive digest_valid high during COLLECT and on the exact timeout cycle -> the COLLECT pulse is ignored; the timeout-cycle pulse yields auth_pass=1.
